// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI4 burst write master.
// Used by axi_burst_writer and axi_wr_addr_gen.
package axi_wr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      WR_RESP,
      DONE
   } wr_state_e;

   localparam logic [1:0] BURST_INCR      = 2'b01;
   localparam logic [1:0] RESP_OKAY       = 2'b00;
   localparam logic [3:0] AWCACHE_DEFAULT = 4'd3;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Burst address register: steps by one burst, wraps at the region end
// and reloads the base address after a frame's final burst.
module axi_wr_addr_gen
   import axi_wr_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    STEP_BYTES   = 512,
   parameter int                    REGION_BYTES = 65536
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  step,
   input  logic                  frame_end,
   output logic [ADDR_WIDTH-1:0] addr
);

   localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(STEP_BYTES);
   localparam logic [ADDR_WIDTH-1:0] LIMIT =
      BASE_ADDR + ADDR_WIDTH'(REGION_BYTES);

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [ADDR_WIDTH-1:0] addr_inc;

   always_comb begin
      addr_inc = addr_q + STEP;
      addr_d   = addr_q;
      if (step) begin
         if (frame_end || (addr_inc == LIMIT)) begin
            addr_d = BASE_ADDR;
         end else begin
            addr_d = addr_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= BASE_ADDR;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr = addr_q;

endmodule

// File: rtl/axi_burst_writer.sv
// AXI4 write master: streams frames to memory as fixed-length INCR bursts.
// Define AXI_WR_BRESP_CHK_EN to latch non-OKAY write responses on o_wr_err.
module axi_burst_writer
   import axi_wr_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    DATA_WIDTH   = 64,
   parameter int                    AW_LEN       = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    REGION_BYTES = 65536
) (
   input  logic                    m_axi_aclk,
   input  logic                    m_axi_areset,
   input  logic                    S_WR_tvalid,
   output logic                    S_WR_tready,
   input  logic [DATA_WIDTH-1:0]   S_WR_tdata,
   input  logic                    S_WR_tlast,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_awid,
   output logic                    m_axi_awlock,
   output logic [3:0]              m_axi_awcache,
   output logic [2:0]              m_axi_awprot,
   output logic [3:0]              m_axi_awqos,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic                    o_wr_done,
   output logic                    o_frame_done,
   output logic                    o_wr_err
);

   localparam int         STRB_W     = DATA_WIDTH / 8;
   localparam int         STEP_BYTES = AW_LEN * STRB_W;
   localparam logic [7:0] LAST_BEAT  = 8'(AW_LEN - 1);

   wr_state_e  state_q, state_d;
   logic       awvalid_q, awvalid_d;
   logic       bready_q, bready_d;
   logic       done_q, done_d;
   logic       fdone_q, fdone_d;
   logic       pad_q, pad_d;
   logic       fend_q, fend_d;
   logic [7:0] cnt_q, cnt_d;
   logic       step;
   logic       in_data;
   logic       pass;
   logic       last_beat;
   logic       w_hs;

   assign in_data   = (state_q == WR_DATA);
   assign pass      = in_data && !pad_q;
   assign last_beat = (cnt_q == LAST_BEAT);

   // Pass-through data path; padding beats keep wvalid up but carry no bytes.
   assign m_axi_wvalid = in_data && (pad_q || S_WR_tvalid);
   assign m_axi_wdata  = pass ? S_WR_tdata : '0;
   assign m_axi_wstrb  = {STRB_W{pass}};
   assign m_axi_wlast  = in_data && last_beat;
   assign S_WR_tready  = pass && m_axi_wready;
   assign w_hs         = m_axi_wvalid && m_axi_wready;

   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      bready_d  = bready_q;
      done_d    = 1'b0;
      fdone_d   = 1'b0;
      pad_d     = pad_q;
      fend_d    = fend_q;
      cnt_d     = cnt_q;
      step      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (S_WR_tvalid) begin
               state_d   = WR_ADDR;
               awvalid_d = 1'b1;
            end
         end
         WR_ADDR: begin
            if (m_axi_awready) begin
               state_d   = WR_DATA;
               awvalid_d = 1'b0;
            end
         end
         WR_DATA: begin
            if (w_hs) begin
               cnt_d = cnt_q + 8'd1;
               if (!pad_q && S_WR_tlast) begin
                  fend_d = 1'b1;
                  pad_d  = !last_beat;
               end
               if (last_beat) begin
                  cnt_d    = '0;
                  state_d  = WR_RESP;
                  bready_d = 1'b1;
               end
            end
         end
         WR_RESP: begin
            if (m_axi_bvalid) begin
               state_d  = DONE;
               bready_d = 1'b0;
               done_d   = 1'b1;
               fdone_d  = fend_q;
               step     = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            pad_d   = 1'b0;
            fend_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         state_q   <= IDLE;
         awvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         done_q    <= 1'b0;
         fdone_q   <= 1'b0;
         pad_q     <= 1'b0;
         fend_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         bready_q  <= bready_d;
         done_q    <= done_d;
         fdone_q   <= fdone_d;
         pad_q     <= pad_d;
         fend_q    <= fend_d;
         cnt_q     <= cnt_d;
      end
   end

   axi_wr_addr_gen #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .BASE_ADDR    (BASE_ADDR),
      .STEP_BYTES   (STEP_BYTES),
      .REGION_BYTES (REGION_BYTES)
   ) u_addr_gen (
      .clk       (m_axi_aclk),
      .rst       (m_axi_areset),
      .step      (step),
      .frame_end (fend_q),
      .addr      (m_axi_awaddr)
   );

`ifdef AXI_WR_BRESP_CHK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if ((state_q == WR_RESP) && m_axi_bvalid &&
          (m_axi_bresp != RESP_OKAY)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign o_wr_err = err_q;
`else
   logic unused_bresp;
   assign unused_bresp = ^m_axi_bresp;
   assign o_wr_err     = 1'b0;
`endif

   assign m_axi_awvalid = awvalid_q;
   assign m_axi_bready  = bready_q;
   assign o_wr_done     = done_q;
   assign o_frame_done  = fdone_q;
   assign m_axi_awlen   = LAST_BEAT;
   assign m_axi_awsize  = 3'(clog2(STRB_W));
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_awid    = 1'b0;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = AWCACHE_DEFAULT;
   assign m_axi_awprot  = 3'd0;
   assign m_axi_awqos   = 4'd0;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Randomized bench for axi_burst_writer against a frame-level model
// of expected bursts, beats and completion pulses.
`timescale 1ns/1ps
module tb_axi_burst_writer;

   localparam int          AWD    = 32;
   localparam int          DW     = 64;
   localparam int          AWL    = 4;
   localparam logic [31:0] BASE   = 32'h0;
   localparam int          REGION = 64;
   localparam int          STEP   = AWL * DW / 8;
`ifdef AXI_WR_BRESP_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  s;
      logic        l;
   } beat_t;

   typedef struct packed {
      logic [63:0] d;
      logic        l;
   } sbeat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          S_WR_tvalid = 1'b0;
   logic          S_WR_tready;
   logic [63:0]   S_WR_tdata = '0;
   logic          S_WR_tlast = 1'b0;
   logic [31:0]   m_axi_awaddr;
   logic [7:0]    m_axi_awlen;
   logic [2:0]    m_axi_awsize;
   logic [1:0]    m_axi_awburst;
   logic          m_axi_awid;
   logic          m_axi_awlock;
   logic [3:0]    m_axi_awcache;
   logic [2:0]    m_axi_awprot;
   logic [3:0]    m_axi_awqos;
   logic          m_axi_awvalid;
   logic          m_axi_awready = 1'b0;
   logic [63:0]   m_axi_wdata;
   logic [7:0]    m_axi_wstrb;
   logic          m_axi_wlast;
   logic          m_axi_wvalid;
   logic          m_axi_wready = 1'b0;
   logic [1:0]    m_axi_bresp = 2'b00;
   logic          m_axi_bvalid = 1'b0;
   logic          m_axi_bready;
   logic          o_wr_done;
   logic          o_frame_done;
   logic          o_wr_err;

   axi_burst_writer #(
      .ADDR_WIDTH   (AWD),
      .DATA_WIDTH   (DW),
      .AW_LEN       (AWL),
      .BASE_ADDR    (BASE),
      .REGION_BYTES (REGION)
   ) dut (
      .m_axi_aclk    (clk),
      .m_axi_areset  (rst),
      .S_WR_tvalid   (S_WR_tvalid),
      .S_WR_tready   (S_WR_tready),
      .S_WR_tdata    (S_WR_tdata),
      .S_WR_tlast    (S_WR_tlast),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awlen   (m_axi_awlen),
      .m_axi_awsize  (m_axi_awsize),
      .m_axi_awburst (m_axi_awburst),
      .m_axi_awid    (m_axi_awid),
      .m_axi_awlock  (m_axi_awlock),
      .m_axi_awcache (m_axi_awcache),
      .m_axi_awprot  (m_axi_awprot),
      .m_axi_awqos   (m_axi_awqos),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wlast   (m_axi_wlast),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .o_wr_done     (o_wr_done),
      .o_frame_done  (o_frame_done),
      .o_wr_err      (o_wr_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state: what the bus must show, derived per frame.
   logic [31:0] exp_aw[$];
   beat_t       exp_w[$];
   bit          exp_fdq[$];
   sbeat_t      s_q[$];
   bit          exp_done = 0;
   bit          exp_fd = 0;
   bit          exp_err = 0;

   // Observation logs for literal checks.
   logic [31:0] aw_log[$];
   beat_t       w_log[$];
   logic        tr_log[$];
   int          done_cnt = 0;
   int          fd_cnt = 0;
   int          w_cnt = 0;

   bit          chk_en = 0;
   int          s_prob = 100;
   int          aw_mode = 0;
   int          w_mode = 0;
   bit          force_err = 0;
   int          b_pend = 0;
   int          aw_wait = 0;
   bit          aw_stall = 0;
   bit          pad_stall = 0;
   logic [31:0] aw_prev = '0;

   task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic void push_frame(int n, bit seq);
      int nb;
      logic [63:0] d;
      nb = (n + AWL - 1) / AWL;
      for (int k = 0; k < nb; k++) begin
         exp_aw.push_back(BASE + 32'((k * STEP) % REGION));
         exp_fdq.push_back(k == nb - 1);
      end
      for (int i = 0; i < nb * AWL; i++) begin
         if (i < n) begin
            d = seq ? 64'(i + 1) : {$urandom(), $urandom()};
            s_q.push_back('{d, (i == n - 1)});
            exp_w.push_back('{d, 8'hff, ((i % AWL) == AWL - 1)});
         end else begin
            exp_w.push_back('{64'd0, 8'h00, ((i % AWL) == AWL - 1)});
         end
      end
   endfunction

   function automatic logic [31:0] aw_at(int i);
      return (i < aw_log.size()) ? aw_log[i] : 32'hdeadbeef;
   endfunction

   function automatic beat_t w_at(int i);
      return (i < w_log.size()) ? w_log[i] : '1;
   endfunction

   function automatic logic tr_at(int i);
      return (i < tr_log.size()) ? tr_log[i] : 1'bx;
   endfunction

   function automatic void clear_logs();
      aw_log.delete();
      w_log.delete();
      tr_log.delete();
      done_cnt = 0;
      fd_cnt = 0;
   endfunction

   task automatic cycle();
      logic  aw_hs, w_hs, b_hs, s_hs;
      beat_t b;
      @(negedge clk);
      if (chk_en) begin
         check("wr_done", o_wr_done, exp_done);
         check("frame_done", o_frame_done, exp_fd);
         check("wr_err", o_wr_err, exp_err);
         if (aw_stall) begin
            check("awvalid_hold", m_axi_awvalid, 1'b1);
            check("awaddr_hold", m_axi_awaddr, aw_prev);
         end
         if (pad_stall) check("pad_wvalid_hold", m_axi_wvalid, 1'b1);
      end
      if (o_wr_done) done_cnt++;
      if (o_frame_done) fd_cnt++;
      exp_done = 1'b0;
      exp_fd = 1'b0;
      aw_hs = m_axi_awvalid && m_axi_awready;
      w_hs  = m_axi_wvalid && m_axi_wready;
      b_hs  = m_axi_bvalid && m_axi_bready;
      s_hs  = S_WR_tvalid && S_WR_tready;
      if (aw_hs) begin
         aw_log.push_back(m_axi_awaddr);
         if (chk_en) begin
            check("aw_expected", exp_aw.size() != 0, 1'b1);
            if (exp_aw.size() != 0)
               check("awaddr", m_axi_awaddr, exp_aw.pop_front());
         end
      end
      if (w_hs) begin
         w_cnt++;
         w_log.push_back('{m_axi_wdata, m_axi_wstrb, m_axi_wlast});
         tr_log.push_back(S_WR_tready);
         if (chk_en) begin
            check("w_expected", exp_w.size() != 0, 1'b1);
            if (exp_w.size() != 0) begin
               b = exp_w.pop_front();
               check("wdata", m_axi_wdata, b.d);
               check("wstrb", m_axi_wstrb, b.s);
               check("wlast", m_axi_wlast, b.l);
               check("tready", S_WR_tready, b.s != 0);
            end
         end
         if (m_axi_wlast) b_pend++;
      end
      if (b_hs && chk_en) begin
         check("b_expected", exp_fdq.size() != 0, 1'b1);
         exp_done = 1'b1;
         exp_fd = (exp_fdq.size() != 0) ? exp_fdq.pop_front() : 1'b0;
         if (CHK && m_axi_bresp != 2'b00) exp_err = 1'b1;
      end
      if (aw_hs) aw_wait = 0;
      else if (m_axi_awvalid) aw_wait++;
      aw_stall  = m_axi_awvalid && !m_axi_awready;
      aw_prev   = m_axi_awaddr;
      pad_stall = m_axi_wvalid && !m_axi_wready && (m_axi_wstrb == 0);
      @(posedge clk);
      #1;
      if (s_hs && s_q.size() != 0) void'(s_q.pop_front());
      if (!(S_WR_tvalid && !s_hs)) begin
         if (s_q.size() > 0 && $urandom_range(0, 99) < s_prob) begin
            S_WR_tvalid = 1'b1;
            S_WR_tdata  = s_q[0].d;
            S_WR_tlast  = s_q[0].l;
         end else begin
            S_WR_tvalid = 1'b0;
            S_WR_tdata  = '0;
            S_WR_tlast  = 1'b0;
         end
      end
      case (aw_mode)
         0: m_axi_awready = 1'b1;
         1: m_axi_awready = 1'($urandom_range(0, 1));
         default: m_axi_awready = (aw_wait >= 5);
      endcase
      case (w_mode)
         0: m_axi_wready = 1'b1;
         1: m_axi_wready = 1'($urandom_range(0, 1));
         default: m_axi_wready = ~m_axi_wready;
      endcase
      if (b_hs) begin
         m_axi_bvalid = 1'b0;
         m_axi_bresp  = 2'b00;
         b_pend--;
      end
      if (!m_axi_bvalid && b_pend > 0 && $urandom_range(0, 9) < 6) begin
         m_axi_bvalid = 1'b1;
         m_axi_bresp  = force_err ? 2'b10 : 2'b00;
         force_err    = 1'b0;
      end
   endtask

   task automatic drain(string nm);
      int n;
      n = 0;
      while (!(exp_aw.size() == 0 && exp_w.size() == 0 &&
               exp_fdq.size() == 0 && s_q.size() == 0 &&
               b_pend == 0 && !m_axi_bvalid && !exp_done) && n < 3000) begin
         cycle();
         n++;
      end
      cycle();
      check({nm, "_timeout"}, n < 3000, 1'b1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awvalid", m_axi_awvalid, 1'b0);
      check("rst_wvalid", m_axi_wvalid, 1'b0);
      check("rst_tready", S_WR_tready, 1'b0);
      check("rst_bready", m_axi_bready, 1'b0);
      check("rst_wstrb", m_axi_wstrb, 8'h00);
      check("rst_done", {o_wr_done, o_frame_done, o_wr_err}, 3'b000);
      check("rst_awaddr", m_axi_awaddr, BASE);
      check("awlen", m_axi_awlen, 8'd3);
      check("awsize", m_axi_awsize, 3'd3);
      check("awburst", m_axi_awburst, 2'b01);
      check("awcache", m_axi_awcache, 4'd3);
      check("aw_zero", {m_axi_awid, m_axi_awlock, m_axi_awprot, m_axi_awqos}, 9'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;

      clear_logs();
      push_frame(8, 1'b1);
      drain("full");
      check("full_aw_n", aw_log.size(), 2);
      check("full_aw0", aw_at(0), 32'h0);
      check("full_aw1", aw_at(1), 32'h20);
      check("full_last4", w_at(3).l, 1'b1);
      check("full_last8", w_at(7).l, 1'b1);
      check("full_d1", w_at(0).d, 64'd1);
      check("full_d8", w_at(7).d, 64'd8);
      check("full_done_n", done_cnt, 2);
      check("full_fd_n", fd_cnt, 1);

      clear_logs();
      push_frame(2, 1'b1);
      push_frame(4, 1'b1);
      drain("early");
      check("early_d2", w_at(1).d, 64'd2);
      check("early_s3", w_at(2).s, 8'h00);
      check("early_d3", w_at(2).d, 64'd0);
      check("early_s4", w_at(3).s, 8'h00);
      check("early_tr3", tr_at(2), 1'b0);
      check("early_tr4", tr_at(3), 1'b0);
      check("early_next_aw", aw_at(1), 32'h0);
      check("early_fd_n", fd_cnt, 2);

      clear_logs();
      aw_mode = 2;
      w_mode = 2;
      push_frame(8, 1'b1);
      drain("bp");
      check("bp_beats", w_log.size(), 8);
      for (int i = 0; i < 8; i++) check("bp_order", w_at(i).d, 64'(i + 1));

      clear_logs();
      aw_mode = 0;
      w_mode = 0;
      push_frame(12, 1'b0);
      drain("wrap");
      check("wrap_aw0", aw_at(0), 32'h0);
      check("wrap_aw1", aw_at(1), 32'h20);
      check("wrap_aw2", aw_at(2), 32'h0);

      for (int r = 0; r < 10; r++) begin
         aw_mode = $urandom_range(0, 2);
         w_mode = $urandom_range(0, 2);
         s_prob = $urandom_range(30, 100);
         push_frame($urandom_range(1, 14), 1'b0);
         if ($urandom_range(0, 1) == 1) push_frame($urandom_range(1, 9), 1'b0);
         drain("rand");
      end

      aw_mode = 0;
      w_mode = 0;
      s_prob = 100;
      force_err = 1'b1;
      push_frame(4, 1'b0);
      drain("err");
      check("err_set", o_wr_err, CHK);
      push_frame(4, 1'b0);
      drain("err2");
      check("err_sticky", o_wr_err, CHK);

      chk_en = 1'b0;
      w_cnt = 0;
      push_frame(8, 1'b1);
      for (int n = 0; n < 200 && w_cnt < 2; n++) cycle();
      check("mid_reached", w_cnt, 2);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_wvalid", m_axi_wvalid, 1'b0);
      check("mid_awvalid", m_axi_awvalid, 1'b0);
      check("mid_tready", S_WR_tready, 1'b0);
      check("mid_bready", m_axi_bready, 1'b0);
      check("mid_err", o_wr_err, 1'b0);
      @(posedge clk);
      #1;
      S_WR_tvalid = 1'b0;
      S_WR_tdata = '0;
      S_WR_tlast = 1'b0;
      m_axi_bvalid = 1'b0;
      m_axi_bresp = 2'b00;
      s_q.delete();
      exp_aw.delete();
      exp_w.delete();
      exp_fdq.delete();
      b_pend = 0;
      aw_wait = 0;
      aw_stall = 0;
      pad_stall = 0;
      exp_done = 0;
      exp_fd = 0;
      exp_err = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;
      clear_logs();
      push_frame(4, 1'b1);
      drain("post_rst");
      check("post_rst_aw", aw_at(0), BASE);
      check("post_rst_d1", w_at(0).d, 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
